hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use interlock, redirect
// flush and multi-cycle-unit stall sequencing, with saturating stall/flush counters.
module hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_addr,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
   input  logic [NUM_SRC-1:0]            id_src_used,
   input  logic [REG_ADDR_W-1:0]         ex_rd_addr,
   input  logic                          ex_reg_write_en,
   input  logic                          ex_mem_read,
   input  logic [REG_ADDR_W-1:0]         mem_rd_addr,
   input  logic                          mem_reg_write_en,
   input  logic [REG_ADDR_W-1:0]         wb_rd_addr,
   input  logic                          wb_reg_write_en,
   input  logic                          ex_redirect,
   input  logic                          mdu_start,
   input  logic                          mdu_done,
   output logic [2*NUM_SRC-1:0]          fwd_sel,
   output logic                          stall_if,
   output logic                          stall_id,
   output logic                          stall_ex,
   output logic                          flush_id,
   output logic                          flush_ex,
   output logic [CNT_W-1:0]              stall_count,
   output logic [CNT_W-1:0]              flush_count
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state;
   logic   src_match;
   logic   load_use;

   always_comb begin
      fwd_sel = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (ex_src_addr[i*REG_ADDR_W +: REG_ADDR_W] != '0) begin
            if (mem_reg_write_en && mem_rd_addr == ex_src_addr[i*REG_ADDR_W +: REG_ADDR_W])
               fwd_sel[2*i +: 2] = 2'b01;
            else if (wb_reg_write_en && wb_rd_addr == ex_src_addr[i*REG_ADDR_W +: REG_ADDR_W])
               fwd_sel[2*i +: 2] = 2'b10;
         end
      end
   end

   always_comb begin
      src_match = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (id_src_used[i] && id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd_addr)
            src_match = 1'b1;
      end
      load_use = src_match && ex_mem_read && ex_reg_write_en && (ex_rd_addr != '0);
   end

   // Controls are combinational so the MDU release and redirect flush act in the same cycle.
   always_comb begin
      stall_if = 1'b0;
      stall_id = 1'b0;
      stall_ex = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      if (!rst) begin
         if (state == BUSY && !mdu_done) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
         end else if (state == IDLE && ex_redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
         end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (mdu_start && !ex_redirect) state <= BUSY;
            BUSY:    if (mdu_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_if && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
         if (flush_id && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule
